// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the 8-bit datapath (slave).
// The master takes IR and the condition flags and drives every register-load,
// bus-mux, ALU-select and memory-write strobe.
interface control_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] IR;
    logic [3:0]       CCR_Result;
    logic             IR_Load;
    logic             MAR_Load;
    logic             PC_Load;
    logic             PC_Inc;
    logic             A_Load;
    logic             B_Load;
    logic [2:0]       ALU_Sel;
    logic             CCR_Load;
    logic [1:0]       Bus1_Sel;
    logic [1:0]       Bus2_Sel;
    logic             write;

    modport master (
        input  IR, CCR_Result,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );

    modport slave (
        output IR, CCR_Result,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );
endinterface

// File: rtl/control_unit.sv
// Moore control FSM for the 8-bit computer: 4-cycle fetch/decode followed by
// per-instruction execute states. Outputs decode the current state (plus IR
// for A/B and ALU selection), so an asynchronous reset immediately presents
// the fetch-0 strobes and drops any pending memory write.
module control_unit #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] LDA_IMM = 8'h86,
    parameter logic [WIDTH-1:0] LDA_DIR = 8'h87,
    parameter logic [WIDTH-1:0] LDB_IMM = 8'h88,
    parameter logic [WIDTH-1:0] LDB_DIR = 8'h89,
    parameter logic [WIDTH-1:0] STA_DIR = 8'h96,
    parameter logic [WIDTH-1:0] STB_DIR = 8'h97,
    parameter logic [WIDTH-1:0] ADD_AB  = 8'h42,
    parameter logic [WIDTH-1:0] SUB_AB  = 8'h43,
    parameter logic [WIDTH-1:0] AND_AB  = 8'h44,
    parameter logic [WIDTH-1:0] OR_AB   = 8'h45,
    parameter logic [WIDTH-1:0] INCA    = 8'h46,
    parameter logic [WIDTH-1:0] INCB    = 8'h47,
    parameter logic [WIDTH-1:0] DECA    = 8'h48,
    parameter logic [WIDTH-1:0] DECB    = 8'h49,
    parameter logic [WIDTH-1:0] XOR_AB  = 8'h4A,
    parameter logic [WIDTH-1:0] NOTA    = 8'h4B,
    parameter logic [WIDTH-1:0] NOTB    = 8'h4C,
    parameter logic [WIDTH-1:0] BRA     = 8'h20,
    parameter logic [WIDTH-1:0] BMI     = 8'h21,
    parameter logic [WIDTH-1:0] BPL     = 8'h22,
    parameter logic [WIDTH-1:0] BEQ     = 8'h23,
    parameter logic [WIDTH-1:0] BNE     = 8'h24,
    parameter logic [WIDTH-1:0] BVS     = 8'h25,
    parameter logic [WIDTH-1:0] BVC     = 8'h26,
    parameter logic [WIDTH-1:0] BCS     = 8'h27,
    parameter logic [WIDTH-1:0] BCC     = 8'h28
) (
    input  logic             clk,
    input  logic             reset,
    control_unit_if.master   bus
);

    typedef enum logic [4:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDI_4, S_LDI_5, S_LDI_6,
        S_LDD_4, S_LDD_5, S_LDD_6, S_LDD_7, S_LDD_8,
        S_ST_4, S_ST_5, S_ST_6, S_ST_7,
        S_DATA_4,
        S_BRT_4, S_BRT_5, S_BRT_6,
        S_BRN_4
    } state_t;

    state_t state_r;
    state_t next_s;
    logic   dst_b_s;

    // Branch condition from flags {N,Z,V,C}; non-branch opcodes never take.
    function automatic logic branch_taken(input logic [WIDTH-1:0] op, input logic [3:0] ccr);
        logic tk;
        case (op)
            BRA:     tk = 1'b1;
            BMI:     tk = ccr[3];
            BPL:     tk = ~ccr[3];
            BEQ:     tk = ccr[2];
            BNE:     tk = ~ccr[2];
            BVS:     tk = ccr[1];
            BVC:     tk = ~ccr[1];
            BCS:     tk = ccr[0];
            BCC:     tk = ~ccr[0];
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    // State register with asynchronous return to fetch-0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH_0;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and Moore output decode; all strobes default inactive.
    always_comb begin
        next_s         = state_r;
        dst_b_s        = 1'b0;
        bus.IR_Load    = 1'b0;
        bus.MAR_Load   = 1'b0;
        bus.PC_Load    = 1'b0;
        bus.PC_Inc     = 1'b0;
        bus.A_Load     = 1'b0;
        bus.B_Load     = 1'b0;
        bus.ALU_Sel    = 3'b000;
        bus.CCR_Load   = 1'b0;
        bus.Bus1_Sel   = 2'b00;
        bus.Bus2_Sel   = 2'b00;
        bus.write      = 1'b0;
        case (state_r)
            S_FETCH_0: begin
                bus.Bus1_Sel = 2'b00;
                bus.Bus2_Sel = 2'b01;
                bus.MAR_Load = 1'b1;
                next_s       = S_FETCH_1;
            end
            S_FETCH_1: begin
                bus.PC_Inc = 1'b1;
                next_s     = S_FETCH_2;
            end
            S_FETCH_2: begin
                bus.Bus2_Sel = 2'b10;
                bus.IR_Load  = 1'b1;
                next_s       = S_DECODE_3;
            end
            S_DECODE_3: begin
                case (bus.IR)
                    LDA_IMM, LDB_IMM: next_s = S_LDI_4;
                    LDA_DIR, LDB_DIR: next_s = S_LDD_4;
                    STA_DIR, STB_DIR: next_s = S_ST_4;
                    ADD_AB, SUB_AB, AND_AB, OR_AB, INCA, INCB,
                    DECA, DECB, XOR_AB, NOTA, NOTB: next_s = S_DATA_4;
                    BRA, BMI, BPL, BEQ, BNE, BVS, BVC, BCS, BCC: begin
                        if (branch_taken(bus.IR, bus.CCR_Result)) begin
                            next_s = S_BRT_4;
                        end else begin
                            next_s = S_BRN_4;
                        end
                    end
                    default: next_s = S_FETCH_0;
                endcase
            end
            S_LDI_4, S_LDD_4, S_ST_4, S_BRT_4: begin
                bus.Bus1_Sel = 2'b00;
                bus.Bus2_Sel = 2'b01;
                bus.MAR_Load = 1'b1;
                case (state_r)
                    S_LDI_4: next_s = S_LDI_5;
                    S_LDD_4: next_s = S_LDD_5;
                    S_ST_4:  next_s = S_ST_5;
                    default: next_s = S_BRT_5;
                endcase
            end
            S_LDI_5: begin
                bus.PC_Inc = 1'b1;
                next_s     = S_LDI_6;
            end
            S_LDD_5: begin
                bus.PC_Inc = 1'b1;
                next_s     = S_LDD_6;
            end
            S_ST_5: begin
                bus.PC_Inc = 1'b1;
                next_s     = S_ST_6;
            end
            S_LDI_6, S_LDD_8: begin
                bus.Bus2_Sel = 2'b10;
                if (bus.IR == LDB_IMM || bus.IR == LDB_DIR) begin
                    bus.B_Load = 1'b1;
                end else begin
                    bus.A_Load = 1'b1;
                end
                next_s = S_FETCH_0;
            end
            S_LDD_6: begin
                bus.Bus2_Sel = 2'b10;
                bus.MAR_Load = 1'b1;
                next_s       = S_LDD_7;
            end
            S_LDD_7: begin
                next_s = S_LDD_8;
            end
            S_ST_6: begin
                bus.Bus2_Sel = 2'b10;
                bus.MAR_Load = 1'b1;
                next_s       = S_ST_7;
            end
            S_ST_7: begin
                if (bus.IR == STB_DIR) begin
                    bus.Bus1_Sel = 2'b10;
                end else begin
                    bus.Bus1_Sel = 2'b01;
                end
                bus.write = 1'b1;
                next_s    = S_FETCH_0;
            end
            S_DATA_4: begin
                bus.Bus2_Sel = 2'b00;
                bus.CCR_Load = 1'b1;
                case (bus.IR)
                    ADD_AB:  bus.ALU_Sel = 3'b000;
                    SUB_AB:  bus.ALU_Sel = 3'b001;
                    AND_AB:  bus.ALU_Sel = 3'b010;
                    OR_AB:   bus.ALU_Sel = 3'b011;
                    INCA:    bus.ALU_Sel = 3'b100;
                    DECA:    bus.ALU_Sel = 3'b101;
                    XOR_AB:  bus.ALU_Sel = 3'b110;
                    NOTA:    bus.ALU_Sel = 3'b111;
                    INCB: begin bus.ALU_Sel = 3'b100; dst_b_s = 1'b1; end
                    DECB: begin bus.ALU_Sel = 3'b101; dst_b_s = 1'b1; end
                    NOTB: begin bus.ALU_Sel = 3'b111; dst_b_s = 1'b1; end
                    default: bus.ALU_Sel = 3'b000;
                endcase
                if (dst_b_s) begin
                    bus.Bus1_Sel = 2'b10;
                    bus.B_Load   = 1'b1;
                end else begin
                    bus.Bus1_Sel = 2'b01;
                    bus.A_Load   = 1'b1;
                end
                next_s = S_FETCH_0;
            end
            S_BRT_5: begin
                next_s = S_BRT_6;
            end
            S_BRT_6: begin
                bus.Bus2_Sel = 2'b10;
                bus.PC_Load  = 1'b1;
                next_s       = S_FETCH_0;
            end
            S_BRN_4: begin
                bus.PC_Inc = 1'b1;
                next_s     = S_FETCH_0;
            end
            default: begin
                next_s = S_FETCH_0;
            end
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM that sequences the 8-bit computer's datapath.
- It is the initiator on the program-memory read interface: it drives MAR/PC loads and consumes bytes returned from synchronous memory with 1-cycle latency.
- It decodes the full instruction set (loads/stores, data manipulations, branches) and issues per-state control strobes to registers, bus muxes, ALU and memory write.

Parameters:
- WIDTH, 8, data/opcode width.
- Opcode parameters use the team encodings: LDA_IMM 86, LDA_DIR 87, LDB_IMM 88, LDB_DIR 89, STA_DIR 96, STB_DIR 97, ADD_AB 42 … NOTB 4C, BRA 20 … BCC 28 (hex).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IR  in  8  instruction register contents
- CCR_Result  in  4  flags {N,Z,V,C}
- IR_Load  out  1  load IR from Bus2
- MAR_Load  out  1  load MAR from Bus2
- PC_Load  out  1  load PC from Bus2
- PC_Inc  out  1  PC <= PC+1
- A_Load  out  1  load A from Bus2
- B_Load  out  1  load B from Bus2
- ALU_Sel  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 INC, 101 DEC, 110 XOR, 111 NOT
- CCR_Load  out  1  load flags from ALU
- Bus1_Sel  out  2  00 PC, 01 A, 10 B
- Bus2_Sel  out  2  00 ALU result, 01 Bus1, 10 from_memory
- write  out  1  memory write strobe (to_memory = Bus1)

Behaviour:
- One state register, asynchronous clear to S_FETCH_0 on reset=0.
- Outputs are purely a function of the current state and IR/CCR_Result; they are never registered.
- Default for every output is 0, except Bus1_Sel=00 and Bus2_Sel=00.
- During reset, outputs equal the S_FETCH_0 decode: MAR_Load=1, Bus2_Sel=01, all other outputs at default.
- Fetch/decode (4 cycles, common to all instructions):
  - F0: Bus1_Sel=PC, Bus2_Sel=Bus1, MAR_Load.
  - F1: PC_Inc (memory registers the read).
  - F2: Bus2_Sel=mem, IR_Load.
  - D3: branch on IR to the first execute state.
- LDx_IMM:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, A_Load or B_Load.
  - Then F0. Total 7 cycles.
- LDx_DIR:
  - E4: MAR<=PC.
  - E5: PC_Inc.
  - E6: Bus2=mem, MAR_Load.
  - E7: wait for memory latency.
  - E8: Bus2=mem, A_Load or B_Load.
  - Total 9 cycles.
- STx_DIR:
  - E4, E5, E6 as for LDx_DIR.
  - E7: Bus1_Sel=A or B, write=1 for exactly one cycle.
  - Total 8 cycles.
- Data manipulation (single cycle E4, total 5 cycles):
  - Bus2=ALU, CCR_Load=1.
  - ALU_Sel is taken from the opcode map above.
  - For ADD/SUB/AND/OR/XOR/INCA/DECA/NOTA: Bus1_Sel=A, A_Load.
  - For INCB/DECB/NOTB: Bus1_Sel=B, B_Load.
- Branches:
  - The condition is evaluated in D3 from CCR_Result: BRA always; BMI N=1; BPL N=0; BEQ Z=1; BNE Z=0; BVS V=1; BVC V=0; BCS C=1; BCC C=0.
  - Taken: E4 MAR<=PC; E5 wait; E6 Bus2=mem, PC_Load. Total 7 cycles.
  - Not taken: E4 PC_Inc skips the operand byte. Total 5 cycles.
- Unknown opcode: D3 returns directly to F0 as a NOP. Total 4 cycles; PC has already advanced by 1.
- Invariants:
  - write is never asserted outside a store's final state.
  - At most one of PC_Load / PC_Inc is asserted in any state.
- Reset asserted mid-instruction: the state returns to F0 immediately and asynchronously. A pending write is dropped in the same cycle.
- Flags are sampled only in D3; a CCR change after D3 does not alter the branch decision.

Test Plan:
- Reset low then released → F0 outputs (MAR_Load=1, Bus2_Sel=01) hold during reset; next edge asserts PC_Inc, then IR_Load with Bus2_Sel=10.
- IR=86 (LDA_IMM) → A_Load=1 with Bus2_Sel=10 exactly 7 cycles after F0; PC_Inc pulsed twice; write stays 0.
- IR=96 (STA_DIR) with operand E0 → MAR_Load in E6 with Bus2_Sel=10; write=1 for one cycle in E7 with Bus1_Sel=01; return to F0 after 8 cycles.
- IR=47 (INCB) → E4 asserts Bus1_Sel=10, ALU_Sel=100, Bus2_Sel=00, B_Load=1, CCR_Load=1, A_Load=0.
- IR=23 (BEQ) with Z=1 → PC_Load in E6 (7 cycles); with Z=0 → single PC_Inc in E4, no PC_Load (5 cycles).
- IR=FF (undefined) → no load/write strobes after IR_Load; F0 re-entered after D3. Reset pulsed in E7 of STA_DIR → write deasserts immediately and the state is F0.
